seq_alu: RTL and testbench
==========================

# seq_alu

Registered, handshaked, width-parametrised ALU that succeeds the combinational `alu_design` in the datapath. It adds a valid/ready interface on both sides and registered results with flags. Division is a multi-cycle iterative restoring divider instead of a combinational one. Shifts take a variable shift amount. It sits between the operand issue stage and the writeback stage, and stalls upstream during division or downstream backpressure.

## Interface
- `WIDTH`, default 8: operand/result width; power of two, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operands and opcode are valid.
- `in_ready`  out  1  block accepts a new operation this cycle.
- `a`, `b`  in  WIDTH each  operands, unsigned unless stated.
- `alu_sel`  in  4  opcode.
- `out_valid`  out  1  result registers hold a completed operation.
- `out_ready`  in  1  consumer takes the result this cycle.
- `result`  out  WIDTH  primary result; equals `quotient` for divide.
- `quotient`, `remainder`  out  WIDTH each  divide outputs; 0 for other opcodes.
- `carry`, `overflow`, `zero`, `div_by_zero`, `illegal_op`  out  1 each  status flags.

## Operation
- Opcodes and results:
  - 0000 ADD: `a+b`.
  - 0001 SUB: `a-b`.
  - 0010 MUL: low WIDTH bits of `a*b`.
  - 0011 DIV.
  - 0100 AND.
  - 0101 OR.
  - 0110 XOR.
  - 0111 NOT: `~a`.
  - 1000 SHL: `a << sh`.
  - 1001 SHR: logical `a >> sh`.
  - `sh = b mod WIDTH`, i.e. the low log2(WIDTH) bits of `b`.
- Illegal opcodes (1010–1111, see Configuration) produce `result`=0 and `illegal_op`=1, with all other flags 0 except `zero`.
- `carry`:
  - ADD: carry-out.
  - SUB: borrow, i.e. `a<b`.
  - SHL with `sh`≠0: last bit shifted out, `a[WIDTH-sh]`.
  - SHR with `sh`≠0: `a[sh-1]`.
  - All other opcodes: 0.
- `overflow`:
  - ADD/SUB: signed two's-complement overflow.
  - MUL: 1 if the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - All other opcodes: 0.
- `zero`: `result`==0, for all opcodes.
- DIV with `b`≠0: restoring divider, one quotient bit per cycle, MSB first, WIDTH iterations.
- DIV with `b`=0: no iteration. `quotient`=all ones, `remainder`=`a`, `div_by_zero`=1, `zero`=0.
- FSM states: IDLE, DIV, HOLD.
  - IDLE → DIV: accepted DIV with `b`≠0.
  - IDLE → HOLD: any other accepted op. The result is captured on the accept edge.
  - DIV → HOLD: after the WIDTH-th iteration edge.
  - HOLD → IDLE: when `out_ready`=1, or directly back to DIV/HOLD if a new op is accepted in the same cycle.
- `in_ready` = (state==IDLE) or (state==HOLD and `out_ready`). It is 0 throughout DIV.
- Accept occurs when `in_valid && in_ready` at a rising edge. Operands are latched then; `a`/`b` may change afterwards.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - `out_valid`=0.
  - `result`, `quotient`, `remainder`, `carry`, `overflow`, `zero`, `div_by_zero`, `illegal_op`=0.
  - `in_ready`=1 once reset is released.
  - Reset mid-DIV aborts the division; no result is produced.
- Non-DIV ops, and DIV with `b`=0: `out_valid`=1 in the cycle after the accept edge (latency 1).
- DIV with `b`≠0: `out_valid`=1 after WIDTH+1 edges from accept (9 cycles for WIDTH=8).
- While `out_valid && !out_ready`: all outputs hold stable and `in_ready`=0.
- Back-to-back: with `out_ready` held 1, one non-DIV op is accepted per cycle (full throughput).
- Simultaneous consume and accept in HOLD: the old result is taken and the new result is loaded on the same edge. `out_valid` stays 1, or drops to 0 if the new op is a DIV with `b`≠0.
- Output registers change only on accept edges, DIV completion, or reset.

## Configuration
- `SEQ_ALU_ROTATE_EN` defined: 1010 = ROL, 1011 = ROR, both by `sh`. `carry`=0, `overflow`=0. 1100–1111 remain illegal.
- Not defined: 1010–1111 are all illegal (`illegal_op`=1, `result`=0, `zero`=1). No rotate logic is synthesised.

## Test plan
All scenarios use WIDTH=8.
- ADD a=200 b=100, `out_ready`=1 → next cycle `result`=44, `carry`=1, `overflow`=0, `out_valid`=1; then ADD 0+0 → `result`=0, `zero`=1.
- SUB a=20 b=50 → `result`=226, `carry`=1; MUL a=25 b=25 → `result`=113, `overflow`=1; MUL 5×6 → 30, `overflow`=0.
- DIV a=25 b=4 → `in_ready`=0 for 8 cycles, `out_valid` 9 cycles after accept with `quotient`=6, `remainder`=1; DIV 10/0 → next cycle `quotient`=255, `remainder`=10, `div_by_zero`=1.
- SHL a=0x11 b=1 → 0x22, `carry`=0; SHR a=0x11 b=1 → 0x08, `carry`=1; SHL a=0x81 b=9 (`sh`=1) → 0x02, `carry`=1.
- Backpressure: `out_ready`=0 after an AND 0xAA&0x0F → `result` holds 0x0A for 5 cycles, `in_ready`=0; raising `out_ready` with `in_valid`=1 and XOR pending → next cycle `result`=0xA5.
- Reset asserted in cycle 4 of DIV 100/10 → `out_valid`=0 and outputs=0 immediately; after release, ADD 1+1 → 2. Opcode 1010 with a=0x81 b=1 → `illegal_op`=1 without the macro; with the macro → 0x03.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered valid/ready ALU with an iterative restoring divider (one quotient bit per cycle).
// Optional feature macro: SEQ_ALU_ROTATE_EN adds ROL (1010) and ROR (1011); otherwise 1010-1111 are illegal.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
`ifdef SEQ_ALU_ROTATE_EN
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
`endif

    logic [1:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d, quot_q, quot_d, rem_q, rem_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             dbz_q, dbz_d, ill_q, ill_d;
    logic [WIDTH-1:0] wq_q, wq_d, wr_q, wr_d, dvs_q, dvs_d;
    logic [SW-1:0]    cnt_q, cnt_d;

    logic [SW-1:0]      sh;
    logic [WIDTH:0]     sum, diff, shl_w, shr_w;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   op_res, op_quot, op_rem;
    logic               op_carry, op_ovf, op_dbz, op_ill;
    logic               accept, div_start;

    assign sh    = b[SW-1:0];
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // Extra bit on each shift catches the last bit shifted out; it is 0 when sh is 0.
    assign shl_w = {1'b0, a} << sh;
    assign shr_w = {a, 1'b0} >> sh;

    always_comb begin
        op_res   = '0;
        op_quot  = '0;
        op_rem   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        op_dbz   = 1'b0;
        op_ill   = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                op_res   = sum[WIDTH-1:0];
                op_carry = sum[WIDTH];
                op_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                op_res   = diff[WIDTH-1:0];
                op_carry = diff[WIDTH];
                op_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
                op_res = prod[WIDTH-1:0];
                op_ovf = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                op_res  = '1;
                op_quot = '1;
                op_rem  = a;
                op_dbz  = 1'b1;
            end
            OP_AND: op_res = a & b;
            OP_OR:  op_res = a | b;
            OP_XOR: op_res = a ^ b;
            OP_NOT: op_res = ~a;
            OP_SHL: begin
                op_res   = shl_w[WIDTH-1:0];
                op_carry = shl_w[WIDTH];
            end
            OP_SHR: begin
                op_res   = shr_w[WIDTH:1];
                op_carry = shr_w[0];
            end
`ifdef SEQ_ALU_ROTATE_EN
            OP_ROL: op_res = WIDTH'(({a, a} << sh) >> WIDTH);
            OP_ROR: op_res = WIDTH'({a, a} >> sh);
`endif
            default: op_ill = 1'b1;
        endcase
    end

    logic [WIDTH:0]   dv_shift, dv_trial;
    logic             dv_ge;
    logic [WIDTH-1:0] dv_q_nxt, dv_r_nxt;

    assign dv_shift = {wr_q, wq_q[WIDTH-1]};
    assign dv_trial = dv_shift - {1'b0, dvs_q};
    assign dv_ge    = ~dv_trial[WIDTH];
    assign dv_q_nxt = {wq_q[WIDTH-2:0], dv_ge};
    assign dv_r_nxt = dv_ge ? dv_trial[WIDTH-1:0] : dv_shift[WIDTH-1:0];

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign div_start = (alu_sel == OP_DIV) && (b != '0);

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can infer a latch.
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        ill_d       = ill_q;
        wq_d        = wq_q;
        wr_d        = wr_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_DIV: begin
                wq_d  = dv_q_nxt;
                wr_d  = dv_r_nxt;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == '0) begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                    result_d    = dv_q_nxt;
                    quot_d      = dv_q_nxt;
                    rem_d       = dv_r_nxt;
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    zero_d      = (dv_q_nxt == '0);
                    dbz_d       = 1'b0;
                    ill_d       = 1'b0;
                end
            end
            S_IDLE, S_HOLD: begin
                if ((state_q == S_HOLD) && out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (div_start) begin
                        state_d     = S_DIV;
                        out_valid_d = 1'b0;
                        wq_d        = a;
                        wr_d        = '0;
                        dvs_d       = b;
                        cnt_d       = SW'(WIDTH - 1);
                    end else begin
                        state_d     = S_HOLD;
                        out_valid_d = 1'b1;
                        result_d    = op_res;
                        quot_d      = op_quot;
                        rem_d       = op_rem;
                        carry_d     = op_carry;
                        ovf_d       = op_ovf;
                        zero_d      = (op_res == '0);
                        dbz_d       = op_dbz;
                        ill_d       = op_ill;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: non-blocking assignments only here; all next-state decisions are made in always_comb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
            // NOTE: divider working registers are reset as well, so an aborted division leaves no residue.
            wq_q        <= '0;
            wr_q        <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
            wq_q        <= wq_d;
            wr_q        <= wr_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign carry       = carry_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: vector table plus hand sequences for seq_alu (WIDTH=8); a scoreboard
// queue holds expected results and a negedge monitor compares each consumed result.
`timescale 1ns/1ps
module tb_seq_alu;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, result, quotient, remainder;
    logic [3:0]   alu_sel;
    logic         carry, overflow, zero, div_by_zero, illegal_op;
    logic [31:0]  obs;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic [4:0]   flg; // {carry, overflow, zero, div_by_zero, illegal_op}
    } exp_t;

    typedef struct {
        logic [3:0]   sel;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        exp_t         e;
        int           lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    exp_t e_pop;
    int   n_applied    = 0;
    int   n_miscompare = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alu_sel    (alu_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .quotient   (quotient),
        .remainder  (remainder),
        .carry      (carry),
        .overflow   (overflow),
        .zero       (zero),
        .div_by_zero(div_by_zero),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    assign obs = {3'b000, result, quotient, remainder, carry, overflow, zero, div_by_zero, illegal_op};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] res, quo, rem, input logic [4:0] flg);
        exp_t e;
        e.res = res;
        e.quo = quo;
        e.rem = rem;
        e.flg = flg;
        return e;
    endfunction

    function automatic vec_t mv(input logic [3:0] sel, input logic [W-1:0] va, vb,
                                input logic [W-1:0] res, quo, rem, input logic [4:0] flg, input int lat);
        vec_t v;
        v.sel = sel;
        v.va  = va;
        v.vb  = vb;
        v.e   = mk(res, quo, rem, flg);
        v.lat = lat;
        return v;
    endfunction

    function automatic logic [31:0] pack_exp(input exp_t e);
        return {3'b000, e.res, e.quo, e.rem, e.flg};
    endfunction

    task automatic drive(input logic [3:0] sel, input logic [W-1:0] va, vb);
        in_valid = 1'b1;
        alu_sel  = sel;
        a        = va;
        b        = vb;
    endtask

    // Called just after the accept edge; counts falling edges until out_valid.
    task automatic wait_out(input string name, input int lat);
        int cyc = 0;
        bit seen = 1'b0;
        while (cyc < 20 && !seen) begin
            @(negedge clk);
            cyc++;
            if (out_valid) seen = 1'b1;
            else check({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        end
        check({name, "_latency"}, cyc, lat);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_applied++;
                n_miscompare++;
                $display("FAIL sb_underflow: got 0x%0h with nothing expected at %0t", obs, $time);
            end else begin
                e_pop = sb_q.pop_front();
                check("sb_out", obs, pack_exp(e_pop));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d vectors applied", n_applied);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;

        vecs.push_back(mv(4'b0000, 8'd200, 8'd100, 8'd44,  8'd0,   8'd0,  5'b10000, 1));
        vecs.push_back(mv(4'b0000, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,  5'b00100, 1));
        vecs.push_back(mv(4'b0000, 8'd100, 8'd100, 8'd200, 8'd0,   8'd0,  5'b01000, 1));
        vecs.push_back(mv(4'b0000, 8'd255, 8'd1,   8'd0,   8'd0,   8'd0,  5'b10100, 1));
        vecs.push_back(mv(4'b0001, 8'd20,  8'd50,  8'd226, 8'd0,   8'd0,  5'b10000, 1));
        vecs.push_back(mv(4'b0001, 8'd128, 8'd1,   8'd127, 8'd0,   8'd0,  5'b01000, 1));
        vecs.push_back(mv(4'b0001, 8'd7,   8'd7,   8'd0,   8'd0,   8'd0,  5'b00100, 1));
        vecs.push_back(mv(4'b0010, 8'd25,  8'd25,  8'd113, 8'd0,   8'd0,  5'b01000, 1));
        vecs.push_back(mv(4'b0010, 8'd5,   8'd6,   8'd30,  8'd0,   8'd0,  5'b00000, 1));
        vecs.push_back(mv(4'b0011, 8'd25,  8'd4,   8'd6,   8'd6,   8'd1,  5'b00000, 9));
        vecs.push_back(mv(4'b0011, 8'd10,  8'd0,   8'd255, 8'd255, 8'd10, 5'b00010, 1));
        vecs.push_back(mv(4'b0011, 8'd3,   8'd7,   8'd0,   8'd0,   8'd3,  5'b00100, 9));
        vecs.push_back(mv(4'b0011, 8'd200, 8'd7,   8'd28,  8'd28,  8'd4,  5'b00000, 9));
        vecs.push_back(mv(4'b0011, 8'd255, 8'd1,   8'd255, 8'd255, 8'd0,  5'b00000, 9));
        vecs.push_back(mv(4'b0100, 8'hAA,  8'h0F,  8'h0A,  8'd0,   8'd0,  5'b00000, 1));
        vecs.push_back(mv(4'b0101, 8'hA0,  8'h05,  8'hA5,  8'd0,   8'd0,  5'b00000, 1));
        vecs.push_back(mv(4'b0110, 8'hFF,  8'hFF,  8'h00,  8'd0,   8'd0,  5'b00100, 1));
        vecs.push_back(mv(4'b0111, 8'h0F,  8'h33,  8'hF0,  8'd0,   8'd0,  5'b00000, 1));
        vecs.push_back(mv(4'b1000, 8'h11,  8'd1,   8'h22,  8'd0,   8'd0,  5'b00000, 1));
        vecs.push_back(mv(4'b1001, 8'h11,  8'd1,   8'h08,  8'd0,   8'd0,  5'b10000, 1));
        vecs.push_back(mv(4'b1000, 8'h81,  8'd9,   8'h02,  8'd0,   8'd0,  5'b10000, 1));
        vecs.push_back(mv(4'b1000, 8'h81,  8'd0,   8'h81,  8'd0,   8'd0,  5'b00000, 1));
        vecs.push_back(mv(4'b1001, 8'hC0,  8'd7,   8'h01,  8'd0,   8'd0,  5'b10000, 1));
        vecs.push_back(mv(4'b1000, 8'h03,  8'd7,   8'h80,  8'd0,   8'd0,  5'b10000, 1));
`ifdef SEQ_ALU_ROTATE_EN
        vecs.push_back(mv(4'b1010, 8'h81,  8'd1,   8'h03,  8'd0,   8'd0,  5'b00000, 1));
        vecs.push_back(mv(4'b1011, 8'h81,  8'd1,   8'hC0,  8'd0,   8'd0,  5'b00000, 1));
`else
        vecs.push_back(mv(4'b1010, 8'h81,  8'd1,   8'h00,  8'd0,   8'd0,  5'b00101, 1));
        vecs.push_back(mv(4'b1011, 8'h81,  8'd1,   8'h00,  8'd0,   8'd0,  5'b00101, 1));
`endif
        vecs.push_back(mv(4'b1111, 8'h05,  8'h05,  8'h00,  8'd0,   8'd0,  5'b00101, 1));

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        alu_sel   = '0;
        #3;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", obs, 32'd0);
        #19 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i].sel, vecs[i].va, vecs[i].vb);
            sb_q.push_back(vecs[i].e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            a        = W'($urandom);
            b        = W'($urandom);
            alu_sel  = 4'($urandom);
            wait_out($sformatf("vec%0d", i), vecs[i].lat);
        end

        // Back-to-back issue, ending in a divide accepted while the previous result is consumed.
        @(posedge clk); #1;
        drive(4'b0000, 8'd1, 8'd2);
        sb_q.push_back(mk(8'd3, 8'd0, 8'd0, 5'b00000));
        @(posedge clk); #1;
        check("b2b_valid0", 32'(out_valid), 32'd1);
        check("b2b_ready0", 32'(in_ready), 32'd1);
        drive(4'b0001, 8'd5, 8'd3);
        sb_q.push_back(mk(8'd2, 8'd0, 8'd0, 5'b00000));
        @(posedge clk); #1;
        check("b2b_valid1", 32'(out_valid), 32'd1);
        check("b2b_result1", 32'(result), 32'd2);
        drive(4'b0110, 8'hF0, 8'h0F);
        sb_q.push_back(mk(8'hFF, 8'd0, 8'd0, 5'b00000));
        @(posedge clk); #1;
        check("b2b_valid2", 32'(out_valid), 32'd1);
        drive(4'b0101, 8'd0, 8'd0);
        sb_q.push_back(mk(8'd0, 8'd0, 8'd0, 5'b00100));
        @(posedge clk); #1;
        check("b2b_zero3", 32'(zero), 32'd1);
        drive(4'b0011, 8'd100, 8'd7);
        sb_q.push_back(mk(8'd14, 8'd14, 8'd2, 5'b00000));
        @(posedge clk); #1;
        check("b2b_div_drop", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        b        = 8'd0;
        wait_out("b2b_div", 9);

        // Backpressure: result holds, then consume and accept on the same edge.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(4'b0100, 8'hAA, 8'h0F);
        sb_q.push_back(mk(8'h0A, 8'd0, 8'd0, 5'b00000));
        @(posedge clk); #1;
        drive(4'b0110, 8'hAA, 8'h0F);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_result", 32'(result), 32'h0A);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        sb_q.push_back(mk(8'hA5, 8'd0, 8'd0, 5'b00000));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_swap_valid", 32'(out_valid), 32'd1);
        check("bp_swap_result", 32'(result), 32'hA5);

        // Reset in the middle of a division: no result may appear afterwards.
        @(posedge clk); #1;
        drive(4'b0011, 8'd100, 8'd10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", obs, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drive(4'b0000, 8'd1, 8'd1);
        sb_q.push_back(mk(8'd2, 8'd0, 8'd0, 5'b00000));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("post_rst", 1);

        @(posedge clk); #1;
        check("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
